// File: rtl/seq_pattern_detector.sv
// ---------------------------------------------------------------------------
// seq_pattern_detector
//   Serial bit-pattern detector with a pattern that can be loaded at runtime.
//   Each bit on `a` is shifted into a history register when `en` is high.
//   `y` pulses for one cycle when the most recent PAT_W bits equal the
//   active pattern. The MSB of the pattern is the first bit received.
//   Matches can overlap or be non-overlapping, and a saturating counter
//   tracks the number of matches.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   en         sample enable for a
//   a          serial data bit
//   overlap    1 = overlapping matches, 0 = restart history after a match
//   pat_load   load pat_in as the active pattern (has priority over en)
//   pat_in     new pattern value, MSB first
//   cnt_clr    synchronous clear of match_cnt and cnt_sat
//   y          registered one-cycle match pulse
//   match_cnt  saturating match count since reset or clear
//   cnt_sat    sticky flag, set when match_cnt reaches all-ones
// ---------------------------------------------------------------------------
module seq_pattern_detector #(
    parameter int               PAT_W   = 5,
    parameter logic [PAT_W-1:0] PATTERN = 5'b10000,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             a,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int               FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [PAT_W-1:0]  pat_q;
    logic [PAT_W-1:0]  hist;
    logic [FILL_W-1:0] fill;

    logic [PAT_W-1:0]  nh;
    logic [FILL_W-1:0] nf;
    logic              m;
    logic [CNT_W-1:0]  cnt_inc;

    // fill guards against matching on zero-padding left behind by reset,
    // a pattern load or a non-overlapping restart.
    always_comb begin
        nh      = {hist[PAT_W-2:0], a};
        nf      = (fill == FILL_MAX) ? fill : fill + 1'b1;
        m       = en && !pat_load && (nf == FILL_MAX) && (nh == pat_q);
        cnt_inc = match_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q <= PATTERN;
            hist  <= '0;
            fill  <= '0;
            y     <= 1'b0;
        end else if (pat_load) begin
            pat_q <= pat_in;
            hist  <= '0;
            fill  <= '0;
            y     <= 1'b0;
        end else if (en) begin
            y <= m;
            if (m && !overlap) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= nh;
                fill <= nf;
            end
        end else begin
            y <= 1'b0;
        end
    end

    // A clear coinciding with a match keeps that match as the first count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else if (cnt_clr) begin
            match_cnt <= m ? CNT_W'(1) : '0;
            cnt_sat   <= 1'b0;
        end else if (m && (match_cnt != CNT_MAX)) begin
            match_cnt <= cnt_inc;
            if (cnt_inc == CNT_MAX) begin
                cnt_sat <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_pattern_detector.sv
module tb_seq_pattern_detector;

    logic       clk;
    logic       rst;
    logic       en;
    logic       a;
    logic       overlap;
    logic       pat_load;
    logic [4:0] pat_in;
    logic       cnt_clr;

    logic       y0;
    logic [7:0] cnt0;
    logic       sat0;
    logic       y1;
    logic [1:0] cnt1;
    logic       sat1;

    int checks = 0;
    int errors = 0;

    seq_pattern_detector dut (
        .clk(clk), .rst(rst), .en(en), .a(a), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .y(y0), .match_cnt(cnt0), .cnt_sat(sat0)
    );

    seq_pattern_detector #(.CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .en(en), .a(a), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .y(y1), .match_cnt(cnt1), .cnt_sat(sat1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic b);
        en = 1'b1;
        a  = b;
        tick();
    endtask

    task automatic idle();
        en = 1'b0;
        a  = 1'b0;
        tick();
    endtask

    task automatic feed_10000();
        feed(1'b1); feed(1'b0); feed(1'b0); feed(1'b0); feed(1'b0);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; a = 1'b0; overlap = 1'b1;
        pat_load = 1'b0; pat_in = '0; cnt_clr = 1'b0;
        #12;
        chk("reset_y",      32'(y0),   0);
        chk("reset_cnt",    32'(cnt0), 0);
        chk("reset_sat",    32'(sat0), 0);
        chk("reset_cnt_c2", 32'(cnt1), 0);
        rst = 1'b1;

        // 1: default pattern 10000
        feed(1'b1); feed(1'b0); feed(1'b0);
        feed(1'b0);
        chk("t1_y_bit4", 32'(y0), 0);
        feed(1'b0);
        chk("t1_y_bit5", 32'(y0), 1);
        chk("t1_cnt",    32'(cnt0), 1);
        idle();
        chk("t1_y_pulse_end", 32'(y0), 0);

        // 2a: load 10101, overlap on
        pat_in = 5'b10101; pat_load = 1'b1; tick(); pat_load = 1'b0;
        chk("t2_load_y", 32'(y0), 0);
        feed(1'b1); feed(1'b0); feed(1'b1);
        feed(1'b0);
        chk("t2o_y_bit4", 32'(y0), 0);
        feed(1'b1);
        chk("t2o_y_bit5", 32'(y0), 1);
        chk("t2o_cnt5",   32'(cnt0), 2);
        feed(1'b0);
        chk("t2o_y_bit6", 32'(y0), 0);
        feed(1'b1);
        chk("t2o_y_bit7", 32'(y0), 1);
        chk("t2o_cnt7",   32'(cnt0), 3);

        cnt_clr = 1'b1; idle(); cnt_clr = 1'b0;
        chk("t2_clr_cnt", 32'(cnt0), 0);

        // 2b: same pattern, overlap off
        overlap = 1'b0;
        pat_load = 1'b1; tick(); pat_load = 1'b0;
        feed(1'b1); feed(1'b0); feed(1'b1); feed(1'b0);
        feed(1'b1);
        chk("t2n_y_bit5", 32'(y0), 1);
        feed(1'b0);
        chk("t2n_y_bit6", 32'(y0), 0);
        feed(1'b1);
        chk("t2n_y_bit7", 32'(y0), 0);
        chk("t2n_cnt",    32'(cnt0), 1);

        // 3: enable gaps
        overlap = 1'b1;
        pat_in = 5'b10000; pat_load = 1'b1; tick(); pat_load = 1'b0;
        feed(1'b1); feed(1'b0); feed(1'b0);
        for (int i = 0; i < 3; i++) begin
            en = 1'b0; a = 1'b1; tick();
            chk("t3_y_en_low", 32'(y0), 0);
        end
        feed(1'b0);
        chk("t3_y_bit4", 32'(y0), 0);
        feed(1'b0);
        chk("t3_y_bit5", 32'(y0), 1);
        chk("t3_cnt",    32'(cnt0), 2);

        // 4: reset mid-stream
        feed(1'b1); feed(1'b0); feed(1'b0);
        en = 1'b0;
        rst = 1'b0; #2;
        chk("t4_rst_cnt", 32'(cnt0), 0);
        chk("t4_rst_y",   32'(y0), 0);
        rst = 1'b1;
        feed(1'b0);
        feed(1'b0);
        chk("t4_no_cross_y", 32'(y0), 0);
        chk("t4_cnt0",       32'(cnt0), 0);
        feed_10000();
        chk("t4_after_y",   32'(y0), 1);
        chk("t4_after_cnt", 32'(cnt0), 1);

        // 5: saturation on the CNT_W=2 instance
        rst = 1'b0; #2; rst = 1'b1;
        feed_10000();
        chk("t5_cnt_m1", 32'(cnt1), 1);
        feed_10000();
        chk("t5_cnt_m2", 32'(cnt1), 2);
        chk("t5_sat_m2", 32'(sat1), 0);
        feed_10000();
        chk("t5_cnt_m3", 32'(cnt1), 3);
        chk("t5_sat_m3", 32'(sat1), 1);
        feed_10000();
        chk("t5_y_m4",   32'(y1), 1);
        chk("t5_cnt_m4", 32'(cnt1), 3);
        chk("t5_sat_m4", 32'(sat1), 1);
        chk("t5_cnt8_m4", 32'(cnt0), 4);
        feed(1'b1); feed(1'b0); feed(1'b0); feed(1'b0);
        cnt_clr = 1'b1;
        feed(1'b0);
        cnt_clr = 1'b0;
        chk("t5_clr_y",    32'(y1), 1);
        chk("t5_clr_cnt",  32'(cnt1), 1);
        chk("t5_clr_sat",  32'(sat1), 0);
        chk("t5_clr_cnt8", 32'(cnt0), 1);

        // 6: load on the edge that would have completed 10000
        feed(1'b1); feed(1'b0); feed(1'b0); feed(1'b0);
        pat_in = 5'b00001; pat_load = 1'b1; en = 1'b1; a = 1'b0;
        tick();
        pat_load = 1'b0;
        chk("t6_load_y",   32'(y0), 0);
        chk("t6_load_cnt", 32'(cnt0), 1);
        feed(1'b1);
        chk("t6_fill_cleared_y", 32'(y0), 0);
        feed(1'b0); feed(1'b0); feed(1'b0);
        feed(1'b0);
        chk("t6_y_bit5", 32'(y0), 0);
        feed(1'b1);
        chk("t6_y_match", 32'(y0), 1);
        chk("t6_cnt",     32'(cnt0), 2);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
